// File: rtl/wash_pkg.sv
// Shared definitions for the wash sequencer: state encodings, program codes
// and the phase-to-actuator table.
package wash_pkg;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FILL1  = 4'd1,
        S_WASH   = 4'd2,
        S_DRAIN1 = 4'd3,
        S_FILL2  = 4'd4,
        S_RINSE  = 4'd5,
        S_DRAIN2 = 4'd6,
        S_SPIN   = 4'd7,
        S_PAUSED = 4'd8
    } state_t;

    localparam logic [2:0] PROG_NORMAL   = 3'd0;
    localparam logic [2:0] PROG_HEAVY    = 3'd1;
    localparam logic [2:0] PROG_DELICATE = 3'd2;

    typedef struct packed {
        logic water_valve;
        logic wash_motor;
        logic drain_pump;
        logic spin_motor;
        logic door_lock;
    } act_t;

    function automatic logic is_running(state_t s);
        return (s != S_IDLE) && (s != S_PAUSED);
    endfunction

    function automatic act_t phase_act(state_t s);
        act_t a;
        a = '0;
        a.door_lock = is_running(s);
        case (s)
            S_FILL1, S_FILL2:          a.water_valve = 1'b1;
            S_WASH, S_RINSE:           a.wash_motor  = 1'b1;
            S_DRAIN1, S_DRAIN2:        a.drain_pump  = 1'b1;
            S_SPIN: begin
                a.drain_pump = 1'b1;
                a.spin_motor = 1'b1;
            end
            default: ;
        endcase
        return a;
    endfunction

    // Successor of each running phase; SPIN wraps back to IDLE.
    function automatic state_t next_phase(state_t s);
        case (s)
            S_FILL1:  return S_WASH;
            S_WASH:   return S_DRAIN1;
            S_DRAIN1: return S_FILL2;
            S_FILL2:  return S_RINSE;
            S_RINSE:  return S_DRAIN2;
            S_DRAIN2: return S_SPIN;
            default:  return S_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/wash_phase_entry.sv
// Phase-entry window: holds timer_reset for RESET_LEN cycles after each entry
// into a running phase, and keeps it high while idle or paused.
module wash_phase_entry #(
    parameter int RESET_LEN = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic enter,
    input  logic hold,
    output logic timer_reset,
    output logic flag_en
);

    localparam int CW = $clog2(RESET_LEN + 1);

    logic [CW-1:0] cnt;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt         <= '0;
            timer_reset <= 1'b1;
        end else if (hold) begin
            cnt         <= '0;
            timer_reset <= 1'b1;
        end else if (enter) begin
            cnt         <= CW'(RESET_LEN - 1);
            timer_reset <= 1'b1;
        end else if (cnt != '0) begin
            cnt         <= cnt - CW'(1);
            timer_reset <= 1'b1;
        end else begin
            timer_reset <= 1'b0;
        end
    end

    // Done flags are only trusted once the timer has been released.
    assign flag_en = ~timer_reset;

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Wash-sequence controller: steps FILL/WASH/DRAIN/FILL/RINSE/DRAIN/SPIN on
// timer done flags, pauses on door open and resumes the interrupted phase.
module wash_cycle_ctrl
    import wash_pkg::*;
#(
    parameter int PROG_W    = 3,
    parameter int RESET_LEN = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              door_closed,
    input  logic [PROG_W-1:0] prog,
    input  logic              tf,
    input  logic              tw,
    input  logic              td,
    input  logic              tr,
    input  logic              ts,
    output logic              timer_reset,
    output logic [PROG_W-1:0] timer_load,
    output logic              water_valve,
    output logic              wash_motor,
    output logic              drain_pump,
    output logic              spin_motor,
    output logic              door_lock,
    output logic              cycle_done,
    output logic [3:0]        phase
);

    state_t state, nxt, resume_reg;
    act_t   act;
    logic   phase_flag, flag_en, enter, hold;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        phase_flag = 1'b0;
        case (state)
            S_FILL1, S_FILL2:   phase_flag = tf;
            S_WASH:             phase_flag = tw;
            S_DRAIN1, S_DRAIN2: phase_flag = td;
            S_RINSE:            phase_flag = tr;
            S_SPIN:             phase_flag = ts;
            default: ;
        endcase
    end

    // Door-open takes priority over a done flag so the interrupted phase is resumed.
    always_comb begin
        nxt = state;
        case (state)
            S_IDLE:   if (start && door_closed) nxt = S_FILL1;
            S_PAUSED: if (start && door_closed) nxt = resume_reg;
            default: begin
                if (!door_closed)                nxt = S_PAUSED;
                else if (flag_en && phase_flag)  nxt = next_phase(state);
            end
        endcase
    end

    assign enter = (nxt != state) && is_running(nxt);
    assign hold  = !is_running(nxt);

    wash_phase_entry #(.RESET_LEN(RESET_LEN)) u_entry (
        .clk         (clk),
        .rst         (reset),
        .enter       (enter),
        .hold        (hold),
        .timer_reset (timer_reset),
        .flag_en     (flag_en)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: resume_reg is reset too, so an async reset leaves no resume memory behind.
            state      <= S_IDLE;
            resume_reg <= S_IDLE;
            timer_load <= '0;
            act        <= '0;
            cycle_done <= 1'b0;
        end else begin
            state      <= nxt;
            act        <= phase_act(nxt);
            cycle_done <= (state == S_SPIN) && (nxt == S_IDLE);
            if (state == S_IDLE && nxt == S_FILL1)
                timer_load <= (prog > PROG_W'(PROG_DELICATE)) ? PROG_W'(PROG_NORMAL) : prog;
            if (state != S_PAUSED && nxt == S_PAUSED)
                resume_reg <= state;
        end
    end

    assign water_valve = act.water_valve;
    assign wash_motor  = act.wash_motor;
    assign drain_pump  = act.drain_pump;
    assign spin_motor  = act.spin_motor;
    assign door_lock   = act.door_lock;
    assign phase       = state;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl: per-cycle comparison against a
// sequence-index model, plus directed scenarios with literal expectations.
module tb_wash_cycle_ctrl;

    localparam int RESET_LEN = 1;

    logic       clk = 1'b0;
    logic       reset, start, door_closed;
    logic [2:0] prog;
    logic       tf, tw, td, tr, ts;
    logic       timer_reset, water_valve, wash_motor, drain_pump, spin_motor;
    logic       door_lock, cycle_done;
    logic [2:0] timer_load;
    logic [3:0] phase;

    int checks = 0;
    int errors = 0;

    wash_cycle_ctrl #(.PROG_W(3), .RESET_LEN(RESET_LEN)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .door_closed (door_closed),
        .prog        (prog),
        .tf          (tf),
        .tw          (tw),
        .td          (td),
        .tr          (tr),
        .ts          (ts),
        .timer_reset (timer_reset),
        .timer_load  (timer_load),
        .water_valve (water_valve),
        .wash_motor  (wash_motor),
        .drain_pump  (drain_pump),
        .spin_motor  (spin_motor),
        .door_lock   (door_lock),
        .cycle_done  (cycle_done),
        .phase       (phase)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: the wash program is a list of seven steps (index 0..6, shown as
    // phase code index+1); each step waits for its own done flag.
    logic       m_run = 1'b0, m_pause = 1'b0, m_done = 1'b0;
    int         m_idx = 0, m_since = 0, m_resume = 0;
    logic [2:0] m_load = 3'd0;

    function automatic logic step_flag(input int idx, input logic [4:0] f);
        // f = {ts, tr, td, tw, tf}
        case (idx)
            0, 3:    return f[0];
            1:       return f[1];
            2, 5:    return f[2];
            4:       return f[3];
            default: return f[4];
        endcase
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_run <= 1'b0; m_pause <= 1'b0; m_done <= 1'b0;
            m_idx <= 0; m_since <= 0; m_resume <= 0; m_load <= 3'd0;
        end else begin
            m_done <= 1'b0;
            if (!m_run && !m_pause) begin
                if (start && door_closed) begin
                    m_run <= 1'b1; m_idx <= 0; m_since <= 0;
                    m_load <= (prog > 3'd2) ? 3'd0 : prog;
                end
            end else if (m_pause) begin
                if (start && door_closed) begin
                    m_pause <= 1'b0; m_run <= 1'b1; m_idx <= m_resume; m_since <= 0;
                end
            end else if (!door_closed) begin
                m_run <= 1'b0; m_pause <= 1'b1; m_resume <= m_idx;
            end else if (m_since >= RESET_LEN && step_flag(m_idx, {ts, tr, td, tw, tf})) begin
                if (m_idx == 6) begin
                    m_run <= 1'b0; m_done <= 1'b1;
                end else begin
                    m_idx <= m_idx + 1; m_since <= 0;
                end
            end else if (m_since < 1000) begin
                m_since <= m_since + 1;
            end
        end
    end

    always @(negedge clk) begin
        int ph;
        ph = m_run ? m_idx + 1 : (m_pause ? 8 : 0);
        check("phase",       32'(phase),       32'(ph));
        check("timer_reset", 32'(timer_reset), 32'(!m_run || m_since < RESET_LEN));
        check("timer_load",  32'(timer_load),  32'(m_load));
        check("water_valve", 32'(water_valve), 32'(m_run && (ph == 1 || ph == 4)));
        check("wash_motor",  32'(wash_motor),  32'(m_run && (ph == 2 || ph == 5)));
        check("drain_pump",  32'(drain_pump),  32'(m_run && (ph == 3 || ph == 6 || ph == 7)));
        check("spin_motor",  32'(spin_motor),  32'(m_run && ph == 7));
        check("door_lock",   32'(door_lock),   32'(m_run));
        check("cycle_done",  32'(cycle_done),  32'(m_done));
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_flag(input int f, input logic v);
        case (f)
            0: tf = v;
            1: tw = v;
            2: td = v;
            3: tr = v;
            default: ts = v;
        endcase
    endtask

    // Hold one done flag until the phase reaches exp, bounded by a cycle budget.
    task automatic advance(input int f, input int exp, input string name);
        int n;
        n = 0;
        set_flag(f, 1'b1);
        do begin
            tick();
            n++;
        end while (phase !== 4'(exp) && n < 10);
        check(name, 32'(phase), 32'(exp));
        set_flag(f, 1'b0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; door_closed = 1'b1; prog = 3'd0;
        tf = 1'b0; tw = 1'b0; td = 1'b0; tr = 1'b0; ts = 1'b0;
        #12;
        check("rst_phase",       32'(phase),       32'd0);
        check("rst_timer_reset", 32'(timer_reset), 32'd1);
        check("rst_timer_load",  32'(timer_load),  32'd0);
        check("rst_door_lock",   32'(door_lock),   32'd0);
        #5 reset = 1'b0;
        tick();

        // 1: full normal cycle
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_fill1",       32'(phase),       32'd1);
        check("t1_valve",       32'(water_valve), 32'd1);
        check("t1_entry_reset", 32'(timer_reset), 32'd1);
        advance(0, 2, "t1_wash");
        advance(1, 3, "t1_drain1");
        advance(2, 4, "t1_fill2");
        advance(0, 5, "t1_rinse");
        advance(3, 6, "t1_drain2");
        advance(2, 7, "t1_spin");
        check("t1_spin_motor", 32'(spin_motor), 32'd1);
        advance(4, 0, "t1_idle");
        check("t1_cycle_done", 32'(cycle_done), 32'd1);
        tick();
        check("t1_done_clear", 32'(cycle_done), 32'd0);

        // 2: out-of-range program maps to normal; later prog changes ignored
        prog = 3'd5; start = 1'b1;
        tick();
        start = 1'b0;
        check("t2_load_mapped", 32'(timer_load), 32'd0);
        advance(0, 2, "t2_wash");
        prog = 3'd2;
        tick();
        tick();
        check("t2_load_kept", 32'(timer_load), 32'd0);

        // 3: door open in WASH pauses, close+start resumes with fresh window
        door_closed = 1'b0;
        tick();
        check("t3_paused",     32'(phase),      32'd8);
        check("t3_motor_off",  32'(wash_motor), 32'd0);
        check("t3_unlock",     32'(door_lock),  32'd0);
        door_closed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t3_resume",     32'(phase),       32'd2);
        check("t3_fresh_reset", 32'(timer_reset), 32'd1);
        tick();

        // 4: door open coincides with tw -> resume WASH, not DRAIN1
        tw = 1'b1; door_closed = 1'b0;
        tick();
        tw = 1'b0;
        check("t4_paused", 32'(phase), 32'd8);
        door_closed = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        check("t4_resume_wash", 32'(phase), 32'd2);
        advance(1, 3, "t4_drain1");
        advance(2, 4, "t4_fill2");
        advance(0, 5, "t4_rinse");
        advance(3, 6, "t4_drain2");
        advance(2, 7, "t4_spin");
        advance(4, 0, "t4_idle");

        // 5: stray td in FILL1 ignored; tw held across WASH entry is masked
        td = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        check("t5_stray_td", 32'(phase), 32'd1);
        td = 1'b0;
        tw = 1'b1;
        advance(0, 2, "t5_wash");
        tw = 1'b1;
        tick();
        check("t5_tw_masked", 32'(phase), 32'd2);
        tick();
        check("t5_tw_taken", 32'(phase), 32'd3);
        tw = 1'b0;

        // 6: async reset mid-RINSE, off the clock edge
        advance(2, 4, "t6_fill2");
        advance(0, 5, "t6_rinse");
        #2 reset = 1'b1;
        #1;
        check("t6_phase",       32'(phase),       32'd0);
        check("t6_motor",       32'(wash_motor),  32'd0);
        check("t6_lock",        32'(door_lock),   32'd0);
        check("t6_timer_reset", 32'(timer_reset), 32'd1);
        #3 reset = 1'b0;
        tick();
        tick();
        check("t6_stays_idle", 32'(phase), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t6_restart_fill1", 32'(phase), 32'd1);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
